// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control sequencer (IDLE/DECODE/EXEC/MEM/WB) driving ALU control and datapath strobes.
// Overflow traps on add/sub/addi are enabled by defining MCC_OVF_TRAP_EN.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        overflow,
    output logic [3:0]  ALU_ctrl,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        pc_write,
    output logic        branch_taken,
    output logic        done,
    output logic        illegal,
    output logic        ovf_trap
);
    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_t;
    typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_t;
`ifdef MCC_OVF_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif
    state_t      state, state_n;
    kind_t       kind;
    logic [31:0] ir, word, d_imm;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [3:0]  d_ctrl, f3_ctrl;
    logic        d_src, d_trap, f3_ok, branch, trap_hit, unused_bits;
    logic        ld, reg_write_n, mem_read_n, mem_write_n, pc_write_n, done_n, illegal_n, ovf_trap_n, done_r;

    // In IDLE the raw fetch word is decoded so an illegal encoding can be flagged on the accept edge.
    assign word        = (state == IDLE) ? instr : ir;
    assign opcode      = word[6:0];
    assign f3          = word[14:12];
    assign f7          = word[31:25];
    assign unused_bits = ^word[19:15];
    assign f3_ok       = (f3 == 3'b000) || (f3 == 3'b010) || (f3[2:1] == 2'b11);
    assign f3_ctrl     = (f3 == 3'b010) ? 4'b0111 : (f3 == 3'b110) ? 4'b0001 : (f3 == 3'b111) ? 4'b0000 : 4'b0010;
    assign d_imm       = (opcode == 7'b0100011) ? {{20{word[31]}}, word[31:25], word[11:7]}
                                                : {{20{word[31]}}, word[31:20]};

    always_comb begin
        kind   = K_ILL;
        d_ctrl = 4'b0010;
        d_src  = 1'b0;
        d_trap = 1'b0;
        case (opcode)
            7'b0110011:
                if (f7 == 7'b0000000 && f3_ok) begin
                    kind   = K_ALU;
                    d_ctrl = f3_ctrl;
                    d_trap = (f3 == 3'b000);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    kind   = K_ALU;
                    d_ctrl = 4'b0110;
                    d_trap = 1'b1;
                end
            7'b0010011:
                if (f3_ok) begin
                    kind   = K_ALU;
                    d_ctrl = f3_ctrl;
                    d_src  = 1'b1;
                    d_trap = (f3 == 3'b000);
                end
            7'b0000011:
                if (f3 == 3'b010) begin
                    kind  = K_LW;
                    d_src = 1'b1;
                end
            7'b0100011:
                if (f3 == 3'b010) begin
                    kind  = K_SW;
                    d_src = 1'b1;
                end
            7'b1100011:
                if (f3[2:1] == 2'b00) begin
                    kind   = f3[0] ? K_BNE : K_BEQ;
                    d_ctrl = 4'b0110;
                end
            default: ;
        endcase
    end

    assign branch   = (kind == K_BEQ) || (kind == K_BNE);
    assign trap_hit = TRAP_EN && d_trap && overflow;

    always_comb begin
        state_n     = state;
        ld          = 1'b0;
        reg_write_n = 1'b0;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        pc_write_n  = 1'b0;
        done_n      = 1'b0;
        illegal_n   = 1'b0;
        ovf_trap_n  = 1'b0;
        case (state)
            IDLE:
                if (instr_valid && instr_ready) begin
                    state_n   = DECODE;
                    illegal_n = (kind == K_ILL);
                    done_n    = (kind == K_ILL);
                end
            DECODE:
                if (kind == K_ILL) state_n = IDLE;
                else begin
                    state_n    = EXEC;
                    ld         = 1'b1;
                    pc_write_n = branch;
                    done_n     = branch;
                end
            EXEC:
                if (branch) state_n = IDLE;
                else if (kind == K_ALU) begin
                    state_n     = WB;
                    reg_write_n = !trap_hit;
                    ovf_trap_n  = trap_hit;
                    done_n      = 1'b1;
                end else begin
                    state_n     = MEM;
                    mem_read_n  = (kind == K_LW);
                    mem_write_n = (kind == K_SW);
                end
            MEM:
                if (!mem_ready) begin
                    mem_read_n  = (kind == K_LW);
                    mem_write_n = (kind == K_SW);
                end else if (kind == K_LW) begin
                    state_n     = WB;
                    reg_write_n = 1'b1;
                    done_n      = 1'b1;
                end else state_n = IDLE;
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ir          <= 32'd0;
            instr_ready <= 1'b1;
            ALU_ctrl    <= 4'b0010;
            alu_src_imm <= 1'b0;
            imm         <= 32'd0;
            reg_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            pc_write    <= 1'b0;
            done_r      <= 1'b0;
            illegal     <= 1'b0;
            ovf_trap    <= 1'b0;
        end else begin
            state       <= state_n;
            if (state == IDLE && instr_valid && instr_ready) ir <= instr;
            instr_ready <= (state_n == IDLE);
            if (ld) begin
                ALU_ctrl    <= d_ctrl;
                alu_src_imm <= d_src;
                imm         <= d_imm;
            end
            reg_write   <= reg_write_n;
            mem_read    <= mem_read_n;
            mem_write   <= mem_write_n;
            pc_write    <= pc_write_n;
            done_r      <= done_n;
            illegal     <= illegal_n;
            ovf_trap    <= ovf_trap_n;
        end
    end

    // A store completes in the very cycle memory acknowledges, and the branch outcome follows the live zero flag.
    assign done         = done_r | (state == MEM && kind == K_SW && mem_ready);
    assign branch_taken = pc_write & (zero ^ (kind == K_BNE));
endmodule
